// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential restoring divider.
package div_pkg;

    localparam int unsigned DIV_W = 33;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must hold the value WIDTH itself.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift in a dividend bit, trial-subtract the divisor.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_W
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             qbit_o
);

    logic [WIDTH:0] trial;
    logic           ge;

    // Compare is W+1 bits wide; the difference always fits back into W bits.
    always_comb begin
        trial  = {rem_i, bit_i};
        ge     = (trial >= {1'b0, dvs_i});
        qbit_o = ge;
        rem_o  = ge ? (trial[WIDTH-1:0] - dvs_i) : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned 2W/W restoring divider, one quotient bit per clock.
// Optional DIV_ERR_EN adds an err output and a one-cycle early exit on overflow/divide-by-zero.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
`ifdef DIV_ERR_EN
    ,
    output logic               err
`endif
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam int unsigned DVD_W = 2 * WIDTH;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   low_q, low_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   remd_q, remd_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   step_rem;
    logic               step_qbit;
    logic               last_step;
`ifdef DIV_ERR_EN
    logic               err_q, err_d;
    logic               ovf;

    // A zero divisor is covered too: the high half is always >= 0.
    assign ovf = (dividend[DVD_W-1:WIDTH] >= divisor);
`endif

    assign last_step = (cnt_q == CNT_W'(1));

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i  (rem_q),
        .bit_i  (low_q[WIDTH-1]),
        .dvs_i  (dvs_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
`ifdef DIV_ERR_EN
                    state_d = ovf ? DONE : RUN;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        low_d  = low_q;
        dvs_d  = dvs_q;
        quot_d = quot_q;
        remd_d = remd_q;
`ifdef DIV_ERR_EN
        err_d  = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    rem_d = dividend[DVD_W-1:WIDTH];
                    low_d = dividend[WIDTH-1:0];
                    dvs_d = divisor;
                    cnt_d = CNT_W'(WIDTH);
`ifdef DIV_ERR_EN
                    if (ovf) begin
                        quot_d = '1;
                        remd_d = '0;
                        err_d  = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                rem_d = step_rem;
                low_d = {low_q[WIDTH-2:0], step_qbit};
                cnt_d = cnt_q - CNT_W'(1);
                if (last_step) begin
                    quot_d = {low_q[WIDTH-2:0], step_qbit};
                    remd_d = step_rem;
`ifdef DIV_ERR_EN
                    err_d  = 1'b0;
`endif
                end
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            low_q  <= '0;
            dvs_q  <= '0;
            quot_q <= '0;
            remd_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef DIV_ERR_EN
            err_q  <= 1'b0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            low_q  <= low_d;
            dvs_q  <= dvs_d;
            quot_q <= quot_d;
            remd_q <= remd_d;
            busy_q <= busy_d;
            done_q <= done_d;
`ifdef DIV_ERR_EN
            err_q  <= err_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = remd_q;
`ifdef DIV_ERR_EN
    assign err       = err_q;
`endif

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: arithmetic reference model plus directed vectors.
module tb_seq_restoring_divider;
    import div_pkg::*;

    localparam int unsigned W  = DIV_W;
    localparam int unsigned DW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dividend;
    logic [W-1:0]  divisor;
    logic          busy, done;
    logic [W-1:0]  quotient, remainder;
`ifdef DIV_ERR_EN
    logic          err;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV_ERR_EN
        ,
        .err       (err)
`endif
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: result by plain division, timing as a countdown of edges to done.
    int           left = 0;
    logic         m_done = 1'b0;
    logic         m_err = 1'b0;
    logic         m_busy;
    logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

    assign m_busy = (left > 0) || m_done;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            left   <= 0;
            m_done <= 1'b0;
            m_err  <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (left > 0) begin
            left <= left - 1;
            if (left == 1) begin
                m_done <= 1'b1;
                m_q    <= p_q;
                m_r    <= p_r;
                m_err  <= 1'b0;
            end
        end else if (start) begin
`ifdef DIV_ERR_EN
            if ((dividend >> W) >= DW'(divisor)) begin
                m_done <= 1'b1;
                m_q    <= '1;
                m_r    <= '0;
                m_err  <= 1'b1;
            end else
`endif
            begin
                p_q  <= W'(dividend / DW'(divisor));
                p_r  <= W'(dividend % DW'(divisor));
                left <= W;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("busy", DW'(busy), DW'(m_busy));
        check("done", DW'(done), DW'(m_done));
        check("quotient", DW'(quotient), DW'(m_q));
        check("remainder", DW'(remainder), DW'(m_r));
`ifdef DIV_ERR_EN
        check("err", DW'(err), DW'(m_err));
`endif
    end

    // One operation: lat counts edges from the start edge through the edge raising done.
    task automatic run_op(input logic [DW-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input int lat, input int repulse);
        int n;
        int busy_n;
        int extra;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n      = 1;
        busy_n = busy ? 1 : 0;
        while (!done && n < 100) begin
            if (n == repulse) begin
                dividend = DW'(999);
                divisor  = W'(5);
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
            if (busy) busy_n++;
        end
        start = 1'b0;
        check("latency", DW'(n), DW'(lat));
        check("busy_cycles", DW'(busy_n), DW'(lat));
        check("lit_quotient", DW'(quotient), DW'(eq));
        check("lit_remainder", DW'(remainder), DW'(er));
        check("model_quotient", DW'(m_q), DW'(eq));
        check("model_remainder", DW'(m_r), DW'(er));
`ifdef DIV_ERR_EN
        check("lit_err", DW'(err), DW'(lat == 1));
`endif
        if (repulse > 0) begin
            extra = 0;
            repeat (40) begin
                @(negedge clk);
                if (done) extra++;
            end
            check("extra_done", DW'(extra), DW'(0));
        end
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = W'(1);
        repeat (2) @(negedge clk);
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_quotient", DW'(quotient), DW'(0));
        rst = 1'b1;

        run_op(DW'(100), W'(7), W'(14), W'(2), W + 1, 0);
        run_op(66'h3_FFFF_FFFC_0000_0001, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, W'(0), W + 1, 0);
        run_op(DW'(83810205), W'(6789), W'(12345), W'(0), W + 1, 0);
        run_op(DW'(0), W'(5), W'(0), W'(0), W + 1, 0);
        run_op(66'h2_0000_0003, W'(2), 33'h1_0000_0001, W'(1), W + 1, 0);
        run_op(DW'(100), W'(7), W'(14), W'(2), W + 1, 10);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        dividend = DW'(100);
        divisor  = W'(7);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_busy", DW'(busy), DW'(0));
        check("arst_done", DW'(done), DW'(0));
        check("arst_quotient", DW'(quotient), DW'(0));
        check("arst_remainder", DW'(remainder), DW'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run_op(DW'(100), W'(7), W'(14), W'(2), W + 1, 0);

`ifdef DIV_ERR_EN
        run_op(DW'(100), W'(0), '1, W'(0), 1, 0);
        run_op(66'h100_0000_0000, W'(3), '1, W'(0), 1, 0);
        run_op(DW'(100), W'(7), W'(14), W'(2), W + 1, 0);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
